// File: rtl/tcdm_bank_responder_if.sv
// TCDM bank-side request/grant bus: the interconnect drives requests,
// the bank answers with a grant and read data.
interface tcdm_bank_responder_if #(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8
);
  logic                    req_i;
  logic                    gnt_o;
  logic [AddrMemWidth-1:0] add_i;
  logic                    wen_i;
  logic [DataWidth-1:0]    wdata_i;
  logic [BeWidth-1:0]      be_i;
  logic [DataWidth-1:0]    rdata_o;

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, rdata_o
  );

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, rdata_o
  );
endinterface

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: byte-enabled word array with optional periodic grant
// throttling and a fixed-latency, fully pipelined read return path.
module tcdm_bank_responder #(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned StallPeriod  = 0
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  tcdm_bank_responder_if.slave bus
);

  localparam int unsigned NumWords = 2 ** AddrMemWidth;
  localparam int unsigned CntWidth = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;

  logic [DataWidth-1:0] mem [NumWords];
  logic                 stall;
  logic                 accept;
  logic                 load;
  logic [DataWidth-1:0] rdata_q;

  // One denied request cycle out of every StallPeriod request cycles.
  if (StallPeriod >= 2) begin : g_stall
    logic [CntWidth-1:0] cnt_q;

    assign stall = (cnt_q == CntWidth'(StallPeriod - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (bus.req_i) begin
        cnt_q <= stall ? '0 : cnt_q + CntWidth'(1);
      end
    end
  end else begin : g_no_stall
    assign stall = 1'b0;
  end

  assign accept    = bus.req_i & ~stall;
  assign load      = accept & ~bus.wen_i;
  assign bus.gnt_o = accept;

  // Array is intentionally not reset so contents survive a bank reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.wen_i) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (bus.be_i[b]) begin
          mem[bus.add_i][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read return path; every stage holds its data when no valid tag arrives.
  if (MemLatency == 1) begin : g_lat1
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else if (load) begin
        rdata_q <= mem[bus.add_i];
      end
    end
  end else begin : g_latn
    logic [MemLatency-2:0] vld_q;
    logic [DataWidth-1:0]  data_q [MemLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q   <= '0;
        rdata_q <= '0;
        for (int unsigned i = 0; i < MemLatency - 1; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= load;
        if (load) begin
          data_q[0] <= mem[bus.add_i];
        end
        for (int unsigned i = 1; i < MemLatency - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
        if (vld_q[MemLatency-2]) begin
          rdata_q <= data_q[MemLatency-2];
        end
      end
    end
  end

  assign bus.rdata_o = rdata_q;

  // Configuration and request-integrity checks.
  always @(posedge clk_i) begin
    assert (MemLatency >= 1) else $error("tcdm_bank_responder: MemLatency must be >= 1");
    assert (StallPeriod != 1) else $error("tcdm_bank_responder: StallPeriod of 1 is illegal");
    assert (BeWidth * 8 == DataWidth) else $error("tcdm_bank_responder: BeWidth*8 != DataWidth");
    if (rst_ni && bus.req_i) begin
      assert (!$isunknown({bus.add_i, bus.wen_i, bus.be_i}))
        else $error("tcdm_bank_responder: X on request fields");
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: three configurations, a reference memory
// model and a due-cycle scoreboard for returned load data.
module tb_tcdm_bank_responder;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned NDUT = 3;
  localparam int unsigned ML0  = 1;
  localparam int unsigned ML1  = 3;
  localparam int unsigned ML2  = 2;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  int            sel   = 0;
  logic          req   = 1'b0;
  logic          wen   = 1'b0;
  logic [AW-1:0] add   = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be    = '0;

  logic          gnt   [NDUT];
  logic [DW-1:0] rdata [NDUT];

  int            cyc      = 0;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] model   [NDUT][4096];
  logic [DW-1:0] last_rd [NDUT];
  logic [15:0]   gnt_hist = '0;
  exp_t          sb [$];

  always #5 clk = ~clk;

  tcdm_bank_responder_if #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus0 ();
  tcdm_bank_responder_if #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus1 ();
  tcdm_bank_responder_if #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus2 ();

  assign bus0.req_i = req & (sel == 0);
  assign bus1.req_i = req & (sel == 1);
  assign bus2.req_i = req & (sel == 2);
  assign {bus0.add_i, bus1.add_i, bus2.add_i}       = {3{add}};
  assign {bus0.wen_i, bus1.wen_i, bus2.wen_i}       = {3{wen}};
  assign {bus0.wdata_i, bus1.wdata_i, bus2.wdata_i} = {3{wdata}};
  assign {bus0.be_i, bus1.be_i, bus2.be_i}          = {3{be}};
  assign gnt[0]   = bus0.gnt_o;
  assign gnt[1]   = bus1.gnt_o;
  assign gnt[2]   = bus2.gnt_o;
  assign rdata[0] = bus0.rdata_o;
  assign rdata[1] = bus1.rdata_o;
  assign rdata[2] = bus2.rdata_o;

  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(ML0), .StallPeriod(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(ML1), .StallPeriod(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  tcdm_bank_responder #(.AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
                        .MemLatency(ML2), .StallPeriod(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  function automatic int ml_of(input int k);
    case (k)
      0:       return int'(ML0);
      1:       return int'(ML1);
      default: return int'(ML2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d, dut %0d)", tag, got, exp, cyc, sel);
  endtask

  // Loads retire on their due cycle; otherwise rdata must hold the last load.
  task automatic check_rd();
    if (sb.size() > 0 && sb[0].due == cyc) begin
      last_rd[sel] = sb[0].data;
      void'(sb.pop_front());
      check("rdata_load", rdata[sel], last_rd[sel]);
    end else begin
      check("rdata_hold", rdata[sel], last_rd[sel]);
    end
  endtask

  task automatic tick(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] b, output logic granted);
    req = r; wen = w; add = a; wdata = d; be = b;
    #1;
    granted  = r & gnt[sel];
    gnt_hist = {gnt_hist[14:0], granted};
    if (granted) begin
      if (w) begin
        for (int i = 0; i < int'(BW); i++) begin
          if (b[i]) model[sel][a][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        sb.push_back('{due: cyc + ml_of(sel), data: model[sel][a]});
      end
    end
    @(negedge clk);
    cyc++;
    check_rd();
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] b);
    logic g;
    int   tries;
    tries = 0;
    do begin
      tick(1'b1, w, a, d, b, g);
      tries++;
    end while (!g && tries < 8);
    if (!g) check("gnt_timeout", DW'(g), DW'(1'b1));
  endtask

  task automatic idle(input int n);
    logic g;
    repeat (n) tick(1'b0, 1'b0, '0, '0, '0, g);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int k = 0; k < int'(NDUT); k++) last_rd[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < int'(NDUT); k++) begin
      check("reset_rdata", rdata[k], 32'h0);
      check("reset_gnt", DW'(gnt[k]), 32'h0);
    end
    rst_n = 1'b1;

    // Basic store/load, latency 1.
    sel = 0;
    xfer(1'b1, 12'h005, 32'hDEADBEEF, 4'hF);
    check("t1_gnt_store", DW'(gnt_hist[0]), 32'h1);
    xfer(1'b0, 12'h005, '0, '0);
    check("t1_gnt_load", DW'(gnt_hist[0]), 32'h1);
    idle(1);
    check("t1_rdata", rdata[0], 32'hDEADBEEF);

    // Partial writes and a be=0 no-op store.
    xfer(1'b1, 12'h010, 32'h11223344, 4'hF);
    xfer(1'b1, 12'h010, 32'hAABBCCDD, 4'b0101);
    xfer(1'b0, 12'h010, '0, '0);
    idle(1);
    check("t2_partial", rdata[0], 32'h11BB33DD);
    xfer(1'b1, 12'h010, 32'hFFFFFFFF, 4'h0);
    xfer(1'b0, 12'h010, '0, '0);
    idle(1);
    check("t2_be_zero", rdata[0], 32'h11BB33DD);

    // Random back-to-back traffic over a pre-written window.
    for (int i = 0; i < 8; i++) xfer(1'b1, AW'(12'h100 + i), $urandom, 4'hF);
    for (int i = 0; i < 30; i++)
      xfer(1'($urandom), AW'(12'h100 + $urandom_range(0, 7)), $urandom, BW'($urandom));
    idle(2);

    // Latency 3: back-to-back loads, then hold.
    sel = 1;
    for (int i = 0; i < 4; i++) xfer(1'b1, AW'(i), DW'(32'hA0 + i), 4'hF);
    for (int i = 0; i < 4; i++) xfer(1'b0, AW'(i), '0, '0);
    idle(5);
    check("t3_hold", rdata[1], 32'h000000A3);

    // Store-then-load with stores interleaved while loads are in flight.
    xfer(1'b1, 12'h020, 32'h12345678, 4'hF);
    xfer(1'b0, 12'h020, '0, '0);
    xfer(1'b1, 12'h030, 32'h00000055, 4'hF);
    xfer(1'b1, 12'h031, 32'h00000066, 4'hF);
    xfer(1'b0, 12'h030, '0, '0);
    xfer(1'b1, 12'h020, 32'h0BADF00D, 4'hF);
    idle(4);
    check("t6_last", rdata[1], 32'h00000055);

    // StallPeriod 4: grant pattern, retries and counter hold across idle.
    sel = 2;
    gnt_hist = '0;
    for (int i = 0; i < 7; i++) xfer(1'b1, AW'(12'h040 + i), DW'(32'hC0 + i), 4'hF);
    check("t4_gnt_pattern", DW'(gnt_hist[8:0]), DW'(9'b111011101));
    idle(2);
    check("t4_gnt_idle", DW'(gnt[2]), 32'h0);
    gnt_hist = '0;
    for (int i = 0; i < 3; i++) xfer(1'b0, AW'(12'h040 + i), '0, '0);
    check("t4_gnt_resume", DW'(gnt_hist[3:0]), DW'(4'b1101));
    idle(3);

    // Reset with a load in flight: dropped, rdata cleared, contents persist.
    xfer(1'b0, 12'h043, '0, '0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    for (int k = 0; k < int'(NDUT); k++) begin
      last_rd[k] = '0;
      check("t5_reset_rdata", rdata[k], 32'h0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    xfer(1'b0, 12'h044, '0, '0);
    idle(3);
    check("t5_persist", rdata[2], 32'h000000C4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Bank-side responder for the TCDM request/grant protocol. One instance terminates each bank output port of the TCDM interconnect.
- Stores words in a byte-enabled array and grants requests, optionally throttling grants on a programmable period.
- Returns read data a fixed MemLatency cycles after each granted request, which is the timing the interconnect expects on its rdata_i inputs.
- Used as the bank model in interconnect benches and as the thin wrapper in front of SRAM macros.

Parameters:
- AddrMemWidth, 12, word-address bits; the array holds 2**AddrMemWidth words.
- DataWidth, 32, word width in bits.
- BeWidth, DataWidth/8, byte-enable width; one bit per byte.
- MemLatency, 1, cycles from the granted-request edge to valid rdata_o; must be ≥1.
- StallPeriod, 0, 0 means always grant; N≥2 means one denied cycle per N request cycles.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  bank request
- gnt_o  out  1  grant; combinational from req_i and the stall counter
- add_i  in  AddrMemWidth  word address within the bank
- wen_i  in  1  1 = store, 0 = load
- wdata_i  in  DataWidth  write data
- be_i  in  BeWidth  byte enables; be_i[b] covers wdata_i[8b+7:8b]
- rdata_o  out  DataWidth  read data, registered

Behaviour:
- One clock (clk_i); reset is asynchronous, active-low (rst_ni). All flops reset asynchronously.
- Reset values:
  - gnt_o = 0 while req_i = 0.
  - rdata_o = 0.
  - Stall counter = 0.
  - All latency-pipeline valid tags = 0.
  - Array contents are NOT reset; the bench must not read unwritten words.
- Grant:
  - gnt_o = req_i & ~stall.
  - stall = (StallPeriod≥2) & (cnt == StallPeriod-1).
  - cnt is $clog2(StallPeriod) bits wide and advances only on cycles with req_i=1.
  - cnt wraps to 0 after the stall cycle; it holds when req_i=0.
  - StallPeriod=1 is illegal; a simulation assertion fires.
- Transaction: a request is accepted at the rising edge where req_i & gnt_o = 1. Ungranted cycles have no side effect.
- Store (wen_i=1):
  - Each byte with be_i[b]=1 is updated at the accept edge.
  - Bytes with be_i=0 keep their old value.
  - be_i=0 is a legal no-op write.
  - No rdata_o update.
- Load (wen_i=0):
  - The array word is sampled at the accept edge.
  - The word and valid tag enter a MemLatency-deep pipeline.
  - rdata_o takes the data when the tag reaches the last stage, i.e. it is valid in cycle t+MemLatency for a load accepted at the end of cycle t.
- rdata_o holds its last load value whenever the final stage carries no valid tag. This covers idle cycles and stores.
- Back-to-back loads: one per cycle, fully pipelined, with no bubble.
- Load after store to the same address on the next cycle returns the new data.
- Only one request per cycle, so there is no intra-cycle read/write conflict.
- Reset mid-operation:
  - All in-flight loads are dropped (tags cleared).
  - rdata_o returns to 0.
  - The counter clears.
  - Array contents persist.
- Simulation assertions:
  - MemLatency≥1.
  - BeWidth*8==DataWidth.
  - add_i, wen_i and be_i are not X while req_i=1.

Test Plan:
- Reset, StallPeriod=0, MemLatency=1: store 0xDEADBEEF to address 0x005 with be=4'hF, then load 0x005 → gnt_o=1 in both cycles; rdata_o=0xDEADBEEF in the cycle after the load accept; rdata_o=0 before the load.
- Partial write: word 0x11223344 at address 0x010, then store 0xAABBCCDD with be=4'b0101, then load → rdata_o=0x11BB33DD.
- MemLatency=3, four back-to-back loads from addresses 0..3 holding 0xA0..0xA3 → rdata_o shows 0xA0, 0xA1, 0xA2, 0xA3 in cycles t+3..t+6, then holds 0xA3 while idle.
- StallPeriod=4, req_i held high for 8 cycles → gnt_o pattern 1,1,1,0,1,1,1,0; each denied request is retried and completes; drop req_i for 2 cycles, resume → counter resumes from its held value.
- MemLatency=2: load accepted, then rst_ni asserted one cycle later → rdata_o=0 and no stale data after reset release; a following load of a previously written word returns the correct data (contents persist).
- Store, then load of the same address on the next cycle, with interleaved stores to other addresses while loads are in flight → rdata_o unchanged on store cycles and the load returns the newly written word.
